// File: rtl/sar_adc_pkg.sv
// Shared types, widths and helpers for the SAR conversion sequencer.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DECIDE,
    ST_DONE
  } sar_state_e;

  localparam int unsigned SAMPLE_CYC_W = 4;

  // One counter serves both the track phase and the DAC settle phase.
  function automatic int unsigned sar_cnt_w(input int unsigned settle_cyc);
    int unsigned w;
    w = $clog2(settle_cyc + 1);
    return (w > SAMPLE_CYC_W) ? w : SAMPLE_CYC_W;
  endfunction

  function automatic int unsigned sar_bit_w(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  function automatic int unsigned sar_latency(input int unsigned sample_cyc,
                                              input int unsigned width,
                                              input int unsigned settle_cyc);
    return ((sample_cyc == 0) ? 1 : sample_cyc) + width * (settle_cyc + 2);
  endfunction

endpackage

// File: rtl/sar_adc_if.sv
// Digital-side request/result handshake of the SAR sequencer.
interface sar_adc_if
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic                    start;
  logic                    continuous;
  logic [SAMPLE_CYC_W-1:0] sample_cyc;
  logic                    busy;
  logic [WIDTH-1:0]        data;
  logic                    valid;
  logic                    ready;

  modport slave (
    input  start, continuous, sample_cyc, ready,
    output busy, data, valid
  );

  modport master (
    output start, continuous, sample_cyc, ready,
    input  busy, data, valid
  );
endinterface

// File: rtl/sar_adc_avg.sv
// Accumulates 2^AVG_LOG2 conversion codes and presents their truncated mean.
module sar_adc_avg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             conv_valid,
  input  logic [WIDTH-1:0] conv_data,
  output logic             last_c,
  output logic [WIDTH-1:0] avg_c
);
  localparam int unsigned SUM_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_q;

  // The mean includes the code arriving this cycle so the result is ready on the same edge.
  assign sum_next = sum_q + SUM_W'(conv_data);
  assign avg_c    = WIDTH'(sum_next >> AVG_LOG2);
  assign last_c   = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (conv_valid) begin
      if (last_c) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else begin
        sum_q <= sum_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion sequencer: track, per-bit settle/strobe/decide, valid/ready result.
// Define SAR_ADC_AVG_EN to average 2^AVG_LOG2 conversions per delivered result.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic             clock,
  input  logic             reset,
  sar_adc_if.slave         bus,
  output logic             samp_o,
  output logic [WIDTH-1:0] dac_p,
  output logic [WIDTH-1:0] dac_n,
  output logic             comp_clk,
  input  logic             comp_p
);
  localparam int unsigned CNT_W = sar_cnt_w(SETTLE_CYC);
  localparam int unsigned BIT_W = sar_bit_w(WIDTH);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || SETTLE_CYC < 1 || AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_param_check
    $error("sar_adc_ctrl: unsupported parameter set");
  end

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dac_n_q;
  logic             samp_q, comp_clk_q, busy_q;

  logic [CNT_W-1:0] samp_load_c;
  logic [WIDTH-1:0] decided_c;
  logic [WIDTH-1:0] next_bit_c;
  logic             conv_done_c;
  logic             avg_last_c;
  logic [WIDTH-1:0] avg_data_c;

  // A zero track length still closes the switches for one cycle.
  assign samp_load_c = (bus.sample_cyc == '0) ? CNT_W'(1) : CNT_W'(bus.sample_cyc);
  assign decided_c   = comp_p ? trial_q : (trial_q & ~(WIDTH'(1) << bit_q));
  assign next_bit_c  = WIDTH'(1) << (bit_q - BIT_W'(1));
  assign conv_done_c = (state_q == ST_DECIDE) && (bit_q == '0);

`ifdef SAR_ADC_AVG_EN
  sar_adc_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clock      (clock),
    .reset      (reset),
    .conv_valid (conv_done_c),
    .conv_data  (decided_c),
    .last_c     (avg_last_c),
    .avg_c      (avg_data_c)
  );
`else
  assign avg_last_c = 1'b1;
  assign avg_data_c = decided_c;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    trial_d = trial_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SAMPLE;
          cnt_d   = samp_load_c;
          trial_d = '0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          bit_d   = BIT_W'(WIDTH - 1);
          trial_d = MSB_CODE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_COMPARE: begin
        state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (bit_q == '0) begin
          trial_d = decided_c;
          state_d = ST_DONE;
          if (avg_last_c) begin
            data_d  = avg_data_c;
            valid_d = 1'b1;
          end
        end else begin
          bit_d   = bit_q - BIT_W'(1);
          trial_d = decided_c | next_bit_c;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // Without a pending result this is an intermediate averaging pass.
        if (!valid_q) begin
          state_d = ST_SAMPLE;
          cnt_d   = samp_load_c;
          trial_d = '0;
        end else if (bus.ready) begin
          valid_d = 1'b0;
          if (bus.continuous || bus.start) begin
            state_d = ST_SAMPLE;
            cnt_d   = samp_load_c;
            trial_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      trial_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      dac_n_q    <= '1;
      samp_q     <= 1'b0;
      comp_clk_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      trial_q    <= trial_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      dac_n_q    <= ~trial_d;
      samp_q     <= (state_d == ST_SAMPLE);
      comp_clk_q <= (state_d == ST_COMPARE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign samp_o    = samp_q;
  assign dac_p     = trial_q;
  assign dac_n     = dac_n_q;
  assign comp_clk  = comp_clk_q;
  assign bus.busy  = busy_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
endmodule
